// File: rtl/load_store_unit.sv
// Byte/half/word load-store sequencer to data_memory (read-modify-write for SB/SH, sign/zero-extended loads).
// Latency: error 1, load 2, SW 2, SB/SH 3 cycles to resp_valid; one request in flight, response held until resp_ready.
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic        r_err;

    logic        w_legal_f3;
    logic        w_misalign;
    logic        w_range;
    logic        w_req_err;
    logic [31:0] w_merged;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request classification, evaluated on the live request inputs in IDLE
    always_comb begin
        w_legal_f3 = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                               : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
        w_range    = ({1'b0, req_addr} >= ADDR_LIMIT);
        w_req_err  = !w_legal_f3 || w_misalign || w_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)                 w_next = S_RESP;
                    else if (!req_store)           w_next = S_READ;
                    else if (req_funct3 == 3'b010) w_next = S_WRITE;
                    else                           w_next = S_READ;
                end
            end
            S_READ:  w_next = r_store ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = resp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_word   <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
            end
            if (r_state == S_READ) begin
                r_word <= mem_rdata;
            end
        end
    end

    // Sub-word stores overlay the new lane onto the word captured in READ
    always_comb begin
        w_merged = r_word;
        case (r_funct3[1:0])
            2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_word[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = r_word;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        resp_err   = (r_state == S_RESP) && r_err;
        resp_rdata = ((r_state == S_RESP) && !r_err && !r_store) ? w_load : 32'h0;
        mem_read   = (r_state == S_READ);
        mem_write  = (r_state == S_WRITE);
        mem_wdata  = (r_state == S_WRITE) ? w_merged : 32'h0;
        mem_addr   = {2'b00, r_addr[31:2]};
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a word-array memory and a behavioural model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int vectors = 0;
    int miscompares = 0;

    // Attached data memory (what the DUT actually writes) and the reference image
    logic [31:0] tb_mem [64];
    logic [31:0] ref_mem [64];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_wa = 6'd0;
    logic [31:0] tb_wd = 32'h0;

    assign mem_rdata = (mem_addr < 32'd64) ? tb_mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (tb_we)          tb_mem[tb_wa] <= tb_wd;
        else if (mem_write) tb_mem[mem_addr[5:0]] <= mem_wdata;
    end

    int          rd_cyc = 0;
    int          wr_cyc = 0;
    logic [31:0] last_waddr = 32'h0;

    always @(posedge clk) begin
        if (reset_n) begin
            if (mem_read) rd_cyc <= rd_cyc + 1;
            if (mem_write) begin
                wr_cyc     <= wr_cyc + 1;
                last_waddr <= mem_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    logic        chk_en = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_err = 1'b0;

    // Per-cycle compare process
    always @(negedge clk) begin
        if (reset_n) begin
            chk("rw_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
            if (!mem_write) chk("wdata_idle_zero", mem_wdata, 32'h0);
            if (chk_en && resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
                chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
            end
        end
    end

    // Behavioural model: architectural result, expected latency and memory traffic
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic e, output logic [31:0] rd,
                                  output int lat, output int nrd, output int nwr);
        logic [31:0] w;
        logic [31:0] mask;
        int          sh;
        int          hs;
        int          idx;
        e = 1'b0;
        rd = 32'h0;
        if (st && f3 > 3'd2) e = 1'b1;
        if (!st && (f3 == 3'd3 || f3 > 3'd5)) e = 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) e = 1'b1;
        if (a >= 32'd256) e = 1'b1;
        if (e) begin
            lat = 1; nrd = 0; nwr = 0;
            return;
        end
        idx = int'(a[7:2]);
        w = ref_mem[idx];
        sh = 8 * int'(a[1:0]);
        hs = a[1] ? 16 : 0;
        if (!st) begin
            lat = 2; nrd = 1; nwr = 0;
            case (f3)
                3'd0: begin rd = (w >> sh) & 32'hFF;   if (rd >= 32'h80)   rd = rd | 32'hFFFFFF00; end
                3'd1: begin rd = (w >> hs) & 32'hFFFF; if (rd >= 32'h8000) rd = rd | 32'hFFFF0000; end
                3'd4: rd = (w >> sh) & 32'hFF;
                3'd5: rd = (w >> hs) & 32'hFFFF;
                default: rd = w;
            endcase
        end else if (f3 == 3'd2) begin
            lat = 2; nrd = 0; nwr = 1;
            ref_mem[idx] = wd;
        end else begin
            lat = 3; nrd = 1; nwr = 1;
            if (f3 == 3'd0) begin
                mask = 32'hFF << sh;
                ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << sh);
            end else begin
                mask = 32'hFFFF << hs;
                ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << hs);
            end
        end
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        logic        e;
        logic [31:0] rd;
        int          elat, enr, enw, lat, r0, w0;
        model(st, f3, a, wd, e, rd, elat, enr, enw);
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        exp_rdata = rd; exp_err = e;
        r0 = rd_cyc; w0 = wr_cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        chk_en = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        chk("latency", 32'(lat), 32'(elat));
        got_rd = resp_rdata;
        got_err = resp_err;
        // Stall in RESP while presenting a request that must be ignored
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
            req_addr = {24'h0, $urandom_range(0, 63) * 4}; req_wdata = $urandom;
            @(negedge clk);
            chk("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk_en = 1'b0;
        chk("resp_dropped", {31'h0, resp_valid}, 32'h0);
        chk("mem_read_cycles", 32'(rd_cyc - r0), 32'(enr));
        chk("mem_write_cycles", 32'(wr_cyc - w0), 32'(enw));
        if (a < 32'd256) chk("mem_word", tb_mem[a[7:2]], ref_mem[a[7:2]]);
    endtask

    logic [31:0] g_rd;
    logic        g_err;

    initial begin
        int n;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            tb_we = 1'b1; tb_wa = 6'(i); tb_wd = $urandom; ref_mem[i] = tb_wd;
            @(posedge clk);
            #1;
        end
        tb_we = 1'b0;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, g_rd, g_err);
        chk("sw_waddr", last_waddr, 32'h4);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, g_rd, g_err);
        chk("lw_lit", g_rd, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h11, 32'h55, 0, g_rd, g_err);
        chk("sb_lit", tb_mem[4], 32'hDEAD55EF);
        do_req(1'b1, 3'd1, 32'h12, 32'h1234, 0, g_rd, g_err);
        chk("sh_lit", tb_mem[4], 32'h123455EF);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, g_rd, g_err);
        chk("lb_lit", g_rd, 32'h00000012);
        do_req(1'b0, 3'd1, 32'h10, 32'h0, 0, g_rd, g_err);
        chk("lh_lit", g_rd, 32'h000055EF);
        do_req(1'b1, 3'd2, 32'h14, 32'h0000F080, 0, g_rd, g_err);
        do_req(1'b0, 3'd0, 32'h14, 32'h0, 0, g_rd, g_err);
        chk("lb_neg_lit", g_rd, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h14, 32'h0, 0, g_rd, g_err);
        chk("lbu_lit", g_rd, 32'h00000080);
        do_req(1'b0, 3'd5, 32'h14, 32'h0, 0, g_rd, g_err);
        chk("lhu_lit", g_rd, 32'h0000F080);
        do_req(1'b0, 3'd2, 32'h12, 32'h0, 0, g_rd, g_err);
        chk("err_lw_mis", {31'h0, g_err}, 32'h1);
        do_req(1'b1, 3'd1, 32'h13, 32'hFFFF, 0, g_rd, g_err);
        chk("err_sh_mis", {31'h0, g_err}, 32'h1);
        do_req(1'b0, 3'd0, 32'h100, 32'h0, 0, g_rd, g_err);
        chk("err_range", {31'h0, g_err}, 32'h1);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, 0, g_rd, g_err);
        chk("err_f3", {31'h0, g_err}, 32'h1);
        chk("err_rdata", g_rd, 32'h0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, g_rd, g_err);
        chk("stall_lw_lit", g_rd, 32'h123455EF);

        // Reset during the WRITE cycle of an SB: memory must be left untouched
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'hAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reached_write", {31'h0, mem_write}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("arst_resp_rdata", resp_rdata, 32'h0);
        chk("arst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("arst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("arst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("arst_word_kept", tb_mem[4], 32'h123455EF);
        reset_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, g_rd, g_err);
        chk("post_rst_lw", g_rd, 32'h123455EF);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 259));
            do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 3)), g_rd, g_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit between the single-cycle core's execute stage and `data_memory`. Accepts one byte/halfword/word access at a time over a valid/ready handshake, converts byte addresses to word indices, performs read-modify-write for sub-word stores, and sign/zero-extends loads. Misaligned, out-of-range and illegal-size requests are rejected without touching memory. The block drives `data_memory`'s `MemRead`, `MemWrite`, `read_address` and `write_data` inputs, and consumes its combinational `MemData_out`.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words in the attached data memory; byte addresses `>= 4*DEPTH_WORDS` are out of range.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request (IDLE only).
- `req_store` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer takes response.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: request rejected (misaligned, out of range, or illegal funct3).
- `mem_read` output 1: to `MemRead`.
- `mem_write` output 1: to `MemWrite`.
- `mem_addr` output 32: word index (`addr >> 2`) to `read_address`.
- `mem_wdata` output 32: to `write_data`.
- `mem_rdata` input 32: from `MemData_out`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch `req_store`, `req_funct3`, `req_addr`, `req_wdata`, then classify:
  - Error if: loads with funct3 not in {000,001,010,100,101}; stores with funct3 not in {000,001,010}; halfword with `addr[0]`=1; word with `addr[1:0]`≠0; `addr >= 4*DEPTH_WORDS`. Error → RESP with `resp_err`=1; memory not accessed.
  - Load → READ. SW → WRITE. SB/SH → READ (read-modify-write).
- READ: `mem_read`=1; capture `mem_rdata` into word register at edge. Load → RESP; store → WRITE.
- WRITE: `mem_write`=1, `mem_wdata` = merged word. SW: full `req_wdata`. SH: `wdata[15:0]` into half `addr[1]`, other half from the captured word. SB: `wdata[7:0]` into byte lane `addr[1:0]`, other lanes from the captured word. → RESP.
- RESP: `resp_valid`=1; `resp_rdata`/`resp_err` held stable until `resp_ready`=1, then → IDLE.
- Load extraction: select byte lane `addr[1:0]` or half `addr[1]` from the captured word; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- `mem_read`/`mem_write` are decoded from state only, never both high. `mem_wdata`=0 outside WRITE. `mem_addr` = latched `addr[31:2]` zero-extended.

## Timing
- Reset (async assert, any state): state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0. An in-flight WRITE is aborted and memory is not written. Deassertion takes effect at the next `clk` edge.
- Latency, from the accepting edge to the first cycle with `resp_valid` high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- Memory write commits at the edge ending WRITE. The write is therefore visible to a subsequent load.
- `req_ready`=0 outside IDLE; `req_valid` is ignored there.
- A RESP→IDLE transition and a new acceptance cannot happen in the same cycle. Back-to-back throughput is one request per latency+1 cycles.
- `resp_ready` held 0: the block stays in RESP indefinitely with outputs stable.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF → `mem_write` pulse with `mem_addr`=4; then LW 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 2 cycles after acceptance.
- With word 4 = 0xDEADBEEF: SB addr 0x11 data 0x55 → word becomes 0xDEAD55EF. SH addr 0x12 data 0x1234 → 0x123455EF. Check 3-cycle latency.
- With word 4 = 0x123455EF: LB 0x13 → 0x00000012; LH 0x10 → 0x000055EF. With word 5 = 0x0000F080: LB 0x14 → 0xFFFFFF80; LBU 0x14 → 0x00000080; LHU 0x14 → 0x0000F080.
- Errors: LW 0x12, SH 0x13, LB 0x100 (DEPTH_WORDS=64), and load funct3 011 → each gives `resp_err`=1 after 1 cycle, `resp_rdata`=0, no `mem_read`/`mem_write` pulse.
- Hold `resp_ready`=0 for 5 cycles in RESP → outputs stable and `req_ready`=0. Drive `req_valid` during the stall → request ignored.
- Assert `reset_n`=0 in WRITE of an SB → outputs at reset values immediately and memory word unchanged. After release, `req_ready`=1 and a new LW is accepted normally.
